truth_table_sweeper: RTL and testbench

Synthesizable exhaustive stimulus generator and self-checker for N-input, 1-output combinational blocks. On `start` it drives every input code from 0 to 2^N−1 (binary or Gray order) for a fixed dwell of cycles. At the end of each dwell it samples the DUT output and compares it against an expected truth table. It sits beside a lab combinational block in the same top level and replaces hand-written per-vector stimulus with one reusable, counted, pass/fail sweep.

---
 rtl/truth_table_sweeper_pkg.sv | 25 ++
 rtl/truth_table_sweeper_if.sv | 40 ++++
 rtl/truth_table_sweeper_dwell_timer.sv | 40 ++++
 rtl/truth_table_sweeper.sv | 172 +++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// -----------------------------------------------------------------------------
// sweeper_pkg
// Shared definitions for the lab truth-table sweepers:
//   - state_t   : sweep FSM states (IDLE, DRIVE, FINISH)
//   - MODE_BIN / MODE_GRAY : code-order selector values
//   - bin2gray  : binary to reflected-Gray conversion, 8 bits wide so every
//                 legal sweeper width (1..8) can use it via a size cast
// -----------------------------------------------------------------------------
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  // Reflected Gray code: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [7:0] bin2gray(input logic [7:0] bin);
    bin2gray = bin ^ (bin >> 1);
  endfunction

endpackage : sweeper_pkg

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Bundles the sweep control, the device-under-test connection and the result
// signals of one truth-table sweeper.
//   start, mode      : sweep request and code order (0 binary, 1 Gray)
//   exp_tt           : expected truth table, bit k = expected f_in at vec = k
//   f_in             : output of the combinational block being checked
//   vec              : input vector driven into that block
//   busy, done       : sweep in progress / one-cycle end-of-sweep pulse
//   pass, err_cnt    : result of the last sweep and its mismatch count
//   first_err_idx/_valid : vec value of the first mismatch and its flag
// master = the sweeper, slave = the surrounding environment.
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if #(
  parameter int N = 4
);

  logic              start;
  logic              mode;
  logic [(2**N)-1:0] exp_tt;
  logic              f_in;
  logic [N-1:0]      vec;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N:0]        err_cnt;
  logic [N-1:0]      first_err_idx;
  logic              first_err_valid;

  modport master (
    input  start, mode, exp_tt, f_in,
    output vec, busy, done, pass, err_cnt, first_err_idx, first_err_valid
  );

  modport slave (
    output start, mode, exp_tt, f_in,
    input  vec, busy, done, pass, err_cnt, first_err_idx, first_err_valid
  );

endinterface : truth_table_sweeper_if

// File: rtl/truth_table_sweeper_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Down-counter that times how long a sweeper holds one vector.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the dwell (counter <= DWELL-1); wins over en
//   en         : count down while the owner is driving a vector
//   expire     : counter at zero, i.e. this is the last cycle of the dwell
// With DWELL = 1 the reload value is zero, so expire is high on every cycle.
// -----------------------------------------------------------------------------
module dwell_timer #(
  parameter int DWELL = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [W-1:0] RELOAD = W'(DWELL - 1);

  logic [W-1:0] cnt_r;

  // Dwell down-counter: reload on load, otherwise count towards zero and stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= RELOAD;
    end else if (en && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == {W{1'b0}});

endmodule : dwell_timer

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Exhaustive stimulus generator and checker for an N-input, 1-output
// combinational block. A start request walks vec through every code
// 0..2^N-1 (binary or Gray order), holding each for DWELL cycles and sampling
// f_in against exp_tt[vec] on the edge that ends the dwell.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : truth_table_sweeper_if.master (see interface header)
// All results are registered; nothing on bus is combinationally driven from
// an input.
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.master bus
);

  localparam logic [N-1:0] SEQ_LAST = {N{1'b1}};

  state_t       state_r;
  logic [N-1:0] seq_r;
  logic         mode_r;
  logic [N-1:0] vec_r;
  logic         busy_r;
  logic         done_r;
  logic         pass_r;
  logic [N:0]   err_cnt_r;
  logic [N-1:0] first_err_idx_r;
  logic         first_err_valid_r;

  logic         timer_load_s;
  logic         timer_en_s;
  logic         expire_s;
  logic         sample_s;
  logic         mismatch_s;
  logic         last_vec_s;
  logic [N:0]   err_next_s;
  logic [N-1:0] seq_next_s;
  logic [N-1:0] vec_next_s;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load_s),
    .en     (timer_en_s),
    .expire (expire_s)
  );

  // Sample/advance decode: what happens at the edge that ends the current dwell.
  always_comb begin
    sample_s     = 1'b0;
    mismatch_s   = 1'b0;
    last_vec_s   = (seq_r == SEQ_LAST);
    err_next_s   = err_cnt_r;
    seq_next_s   = seq_r + N'(1);
    vec_next_s   = vec_r;
    timer_en_s   = (state_r == DRIVE);
    timer_load_s = 1'b0;

    if ((state_r == DRIVE) && expire_s) begin
      sample_s   = 1'b1;
      mismatch_s = (bus.f_in != bus.exp_tt[vec_r]);
      err_next_s = err_cnt_r + (N+1)'(mismatch_s);
    end else begin
      sample_s   = 1'b0;
    end

    // The next code is derived from the incremented sequence value, so Gray
    // mode never needs its own counter.
    if (mode_r == MODE_BIN) begin
      vec_next_s = seq_next_s;
    end else begin
      vec_next_s = N'(bin2gray(8'(seq_next_s)));
    end

    // The timer restarts when a sweep is accepted and on every non-terminal
    // sample; after the terminal sample it is left alone.
    if ((state_r == IDLE) && bus.start) begin
      timer_load_s = 1'b1;
    end else if (sample_s && !last_vec_s) begin
      timer_load_s = 1'b1;
    end else begin
      timer_load_s = 1'b0;
    end
  end

  // Sweep FSM, sequence counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      seq_r             <= {N{1'b0}};
      mode_r            <= MODE_BIN;
      vec_r             <= {N{1'b0}};
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
      pass_r            <= 1'b0;
      err_cnt_r         <= {(N+1){1'b0}};
      first_err_idx_r   <= {N{1'b0}};
      first_err_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r           <= DRIVE;
            seq_r             <= {N{1'b0}};
            mode_r            <= bus.mode;
            // Code 0 is the first code in both orders.
            vec_r             <= {N{1'b0}};
            busy_r            <= 1'b1;
            pass_r            <= 1'b0;
            err_cnt_r         <= {(N+1){1'b0}};
            first_err_valid_r <= 1'b0;
          end else begin
            busy_r <= 1'b0;
          end
        end

        DRIVE: begin
          if (sample_s) begin
            err_cnt_r <= err_next_s;
            if (mismatch_s && !first_err_valid_r) begin
              first_err_idx_r   <= vec_r;
              first_err_valid_r <= 1'b1;
            end else begin
              first_err_valid_r <= first_err_valid_r;
            end
            if (last_vec_s) begin
              // pass uses the count that already includes the final sample.
              state_r <= FINISH;
              done_r  <= 1'b1;
              pass_r  <= (err_next_s == {(N+1){1'b0}});
            end else begin
              seq_r <= seq_next_s;
              vec_r <= vec_next_s;
            end
          end else begin
            state_r <= DRIVE;
          end
        end

        FINISH: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec             = vec_r;
  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.pass            = pass_r;
  assign bus.err_cnt         = err_cnt_r;
  assign bus.first_err_idx   = first_err_idx_r;
  assign bus.first_err_valid = first_err_valid_r;

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Directed bench: a 4-input sweeper (DWELL 2) beside a behavioural block whose
// faults are selectable, and a 3-input sweeper (DWELL 2) for the Gray order.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  truth_table_sweeper_if #(.N(4)) if4 ();
  truth_table_sweeper_if #(.N(3)) if3 ();

  // 0 = matching block, 1 = output flipped at codes 5 and 12, 2 = stuck at 0
  int fault_sel = 0;

  int n_vec = 0;
  int n_err = 0;
  int done_seen4 = 0;

  truth_table_sweeper #(.N(4), .DWELL(2)) u_sweep4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  truth_table_sweeper #(.N(3), .DWELL(2)) u_sweep3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  always #5 clk = ~clk;

  // Behavioural combinational blocks under test.
  assign if4.f_in = (fault_sel == 2) ? 1'b0 :
                    (fault_sel == 1) ? (if4.exp_tt[if4.vec] ^ ((if4.vec == 4'd5) || (if4.vec == 4'd12))) :
                    if4.exp_tt[if4.vec];
  assign if3.f_in = if3.exp_tt[if3.vec];

  always @(negedge clk) if (if4.done) done_seen4++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, "_vec"},   32'(if4.vec), 32'd0);
    chk({tag, "_busy"},  32'(if4.busy), 32'd0);
    chk({tag, "_done"},  32'(if4.done), 32'd0);
    chk({tag, "_pass"},  32'(if4.pass), 32'd0);
    chk({tag, "_err"},   32'(if4.err_cnt), 32'd0);
    chk({tag, "_fidx"},  32'(if4.first_err_idx), 32'd0);
    chk({tag, "_fval"},  32'(if4.first_err_valid), 32'd0);
  endtask

  // Runs one 4-input sweep from a start pulse to busy falling. poke_at pulses
  // start again at that busy cycle; poke_fin pulses it during FINISH.
  task automatic sweep4(input int poke_at, input bit poke_fin,
                        output int busy_n, output int done_n, output logic pass_done);
    busy_n = 0; done_n = 0; pass_done = 1'bx;
    @(negedge clk) if4.start = 1'b1;
    @(negedge clk) if4.start = 1'b0;
    while (if4.busy && busy_n < 200) begin
      if (busy_n == poke_at) chk("hs_vec_at_poke", 32'(if4.vec), 32'd3);
      if (if4.done) begin
        done_n++;
        pass_done = if4.pass;
      end
      if4.start = (busy_n == poke_at) || (poke_fin && if4.done);
      busy_n++;
      @(negedge clk);
    end
    if4.start = 1'b0;
  endtask

  logic [2:0] gray_exp [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  initial begin
    int   busy_n;
    int   done_n;
    int   done_before;
    logic pass_done;

    if4.start = 1'b0; if4.mode = 1'b0; if4.exp_tt = 16'hA5A5;
    if3.start = 1'b0; if3.mode = 1'b1; if3.exp_tt = 8'b1001_0110;

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero4("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean sweep: 16 vectors x 2 cycles + FINISH = 33 busy cycles
    fault_sel = 0;
    sweep4(-1, 1'b0, busy_n, done_n, pass_done);
    chk("clean_busy_len", 32'(busy_n), 32'd33);
    chk("clean_done_cnt", 32'(done_n), 32'd1);
    chk("clean_pass_at_done", 32'(pass_done), 32'd1);
    chk("clean_pass", 32'(if4.pass), 32'd1);
    chk("clean_err", 32'(if4.err_cnt), 32'd0);
    chk("clean_fval", 32'(if4.first_err_valid), 32'd0);
    chk("clean_vec_hold", 32'(if4.vec), 32'd15);

    // Injected faults at codes 5 and 12
    fault_sel = 1;
    sweep4(-1, 1'b0, busy_n, done_n, pass_done);
    chk("fault_err", 32'(if4.err_cnt), 32'd2);
    chk("fault_fidx", 32'(if4.first_err_idx), 32'd5);
    chk("fault_fval", 32'(if4.first_err_valid), 32'd1);
    chk("fault_pass", 32'(if4.pass), 32'd0);

    // Stuck-at-0 output against an all-ones table
    fault_sel = 2;
    if4.exp_tt = 16'hFFFF;
    sweep4(-1, 1'b0, busy_n, done_n, pass_done);
    chk("stuck_err", 32'(if4.err_cnt), 32'd16);
    chk("stuck_fidx", 32'(if4.first_err_idx), 32'd0);
    chk("stuck_fval", 32'(if4.first_err_valid), 32'd1);
    chk("stuck_pass_at_done", 32'(pass_done), 32'd0);

    // Handshake: start again at vector 3 (busy cycle 6) and during FINISH
    fault_sel = 0;
    if4.exp_tt = 16'hA5A5;
    sweep4(6, 1'b1, busy_n, done_n, pass_done);
    chk("hs_busy_len", 32'(busy_n), 32'd33);
    chk("hs_done_cnt", 32'(done_n), 32'd1);
    chk("hs_pass", 32'(if4.pass), 32'd1);
    repeat (3) @(negedge clk);
    chk("hs_no_restart", 32'(if4.busy), 32'd0);

    // Mid-sweep reset at vector 7 with errors accumulating
    fault_sel = 2;
    if4.exp_tt = 16'hFFFF;
    done_before = done_seen4;
    @(negedge clk) if4.start = 1'b1;
    @(negedge clk) if4.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mrst_vec_before", 32'(if4.vec), 32'd7);
    chk("mrst_err_before", 32'(if4.err_cnt), 32'd7);
    rst_n = 1'b0;
    #1;
    chk_zero4("mrst");
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mrst_no_done", 32'(done_seen4 - done_before), 32'd0);
    chk("mrst_idle", 32'(if4.busy), 32'd0);
    fault_sel = 0;
    if4.exp_tt = 16'hA5A5;
    sweep4(-1, 1'b0, busy_n, done_n, pass_done);
    chk("mrst_resweep_len", 32'(busy_n), 32'd33);
    chk("mrst_resweep_err", 32'(if4.err_cnt), 32'd0);
    chk("mrst_resweep_pass", 32'(if4.pass), 32'd1);

    // Gray order on the 3-input sweeper
    busy_n = 0; done_n = 0; pass_done = 1'bx;
    @(negedge clk) if3.start = 1'b1;
    @(negedge clk) begin if3.start = 1'b0; if3.mode = 1'b0; end
    while (if3.busy && busy_n < 100) begin
      if (busy_n < 16) chk($sformatf("gray_vec_c%0d", busy_n), 32'(if3.vec), 32'(gray_exp[busy_n / 2]));
      if (if3.done) begin
        done_n++;
        pass_done = if3.pass;
      end
      busy_n++;
      @(negedge clk);
    end
    chk("gray_busy_len", 32'(busy_n), 32'd17);
    chk("gray_done_cnt", 32'(done_n), 32'd1);
    chk("gray_pass", 32'(pass_done), 32'd1);
    chk("gray_err", 32'(if3.err_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_truth_table_sweeper
